// File: rtl/data_writer_pkg.sv
// Shared definitions for the capture/replay pair (data_writer, data_reader).
// Latency: n/a (types and constant helpers only).
// Backpressure: n/a.
//
// Contents:
//   state_t      : one-hot capture/replay FSM states
//   clog2_min1() : log2 that never yields a zero-width vector
//   wcnt_width() : width able to hold nm * 2**n exactly
package data_writer_pkg;

  typedef enum logic [2:0] {
    INIT_ST  = 3'b001,
    WRITE_ST = 3'b010,
    END_ST   = 3'b100
  } state_t;

  function automatic int clog2_min1(input int value);
    return (value <= 2) ? 1 : $clog2(value);
  endfunction

  // nm is a power of two, so nm * 2**n needs n + log2(nm) + 1 bits.
  function automatic int wcnt_width(input int nm, input int n);
    return n + $clog2(nm) + 1;
  endfunction

endpackage

// File: rtl/data_writer_synchronizer_n.sv
// Multi-flop level synchronizer for slow control levels crossing into aclk.
// Latency: STAGES aclk edges from a stable input level to dout.
// Backpressure: none; pure level transfer, pulses shorter than a cycle may be lost.
//
// Ports:
//   aclk, aresetn : clock, asynchronous active-low reset (clears every stage)
//   din           : asynchronous level input, WIDTH bits
//   dout          : synchronized level, WIDTH bits
module synchronizer_n #(
  parameter int STAGES = 2,
  parameter int WIDTH  = 1
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage_q [STAGES];

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < STAGES; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= din;
      for (int i = 1; i < STAGES; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign dout = stage_q[STAGES-1];

endmodule

// File: rtl/data_writer.sv
// Capture stage: stripes s_axis words round-robin over NM memories, address-major, for data_reader replay.
// Latency: memory write strobes/address/data are registered, one aclk after the accepting handshake.
// Backpressure: s_axis_tready is high only while capturing (state only); words offered otherwise stall.
//
// Ports:
//   aclk, aresetn        : clock, asynchronous active-low reset
//   s_axis_tvalid/tready : input stream handshake
//   s_axis_tdata         : B-bit input word
//   s_axis_tlast         : last word of the capture
//   mem_we               : NM per-memory write enables (one-hot or zero)
//   mem_addr             : N-bit write address shared by all memories
//   mem_di               : NM*B write data, the word replicated on every lane
//   START_REG            : arm level from the register block (other clock domain)
//   DONE_REG             : capture finished, held until the next arm
//   WCNT_REG             : words written in the last or current capture
module data_writer
  import data_writer_pkg::*;
#(
  parameter  int NM  = 8,
  parameter  int N   = 8,
  parameter  int B   = 8,
  localparam int NMW = clog2_min1(NM),
  localparam int WCW = wcnt_width(NM, N)
) (
  input  logic            aclk,
  input  logic            aresetn,
  input  logic            s_axis_tvalid,
  output logic            s_axis_tready,
  input  logic [B-1:0]    s_axis_tdata,
  input  logic            s_axis_tlast,
  output logic [NM-1:0]   mem_we,
  output logic [N-1:0]    mem_addr,
  output logic [NM*B-1:0] mem_di,
  input  logic            START_REG,
  output logic            DONE_REG,
  output logic [WCW-1:0]  WCNT_REG
);

  state_t          state_q;
  state_t          state_d;
  logic            start_sync;
  logic [NMW-1:0]  cnt_nm_q;
  logic [N-1:0]    cnt_addr_q;
  logic            hs;
  logic            last_lane;
  logic            full;
  logic            enter_end;

  synchronizer_n #(
    .STAGES (2),
    .WIDTH  (1)
  ) u_start_sync (
    .aclk    (aclk),
    .aresetn (aresetn),
    .din     (START_REG),
    .dout    (start_sync)
  );

  // tready is a pure function of state so it can never combinationally
  // depend on tvalid.
  assign s_axis_tready = (state_q == WRITE_ST);
  assign hs            = s_axis_tvalid & s_axis_tready;
  assign last_lane     = (cnt_nm_q == NMW'(NM - 1));
  assign full          = last_lane & (cnt_addr_q == '1);

  always_comb begin
    state_d = state_q;
    case (state_q)
      INIT_ST: begin
        if (start_sync) begin
          state_d = WRITE_ST;
        end
      end
      WRITE_ST: begin
        // Losing START ends the capture immediately; a word accepted in
        // this same cycle (tready was already high) is still written.
        // tlast and full together still leave only once.
        if (!start_sync || (hs && (s_axis_tlast || full))) begin
          state_d = END_ST;
        end
      end
      END_ST: begin
        if (!start_sync) begin
          state_d = INIT_ST;
        end
      end
      default: begin
        state_d = INIT_ST;
      end
    endcase
  end

  assign enter_end = (state_q == WRITE_ST) && (state_d == END_ST);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= INIT_ST;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cnt_nm_q   <= '0;
      cnt_addr_q <= '0;
      mem_we     <= '0;
      mem_addr   <= '0;
      mem_di     <= '0;
      DONE_REG   <= 1'b0;
      WCNT_REG   <= '0;
    end else begin
      // Write strobes are single-cycle; address and data hold between writes.
      mem_we <= '0;
      case (state_q)
        INIT_ST: begin
          cnt_nm_q   <= '0;
          cnt_addr_q <= '0;
          if (start_sync) begin
            WCNT_REG <= '0;
            DONE_REG <= 1'b0;
          end
        end
        WRITE_ST: begin
          if (hs) begin
            mem_we   <= NM'(1) << cnt_nm_q;
            mem_addr <= cnt_addr_q;
            mem_di   <= {NM{s_axis_tdata}};
            WCNT_REG <= WCNT_REG + WCW'(1);
            // Lane advances every word; the row address advances after the
            // last lane, giving word k -> lane k%NM, address k/NM.
            if (last_lane) begin
              cnt_nm_q   <= '0;
              cnt_addr_q <= cnt_addr_q + N'(1);
            end else begin
              cnt_nm_q <= cnt_nm_q + NMW'(1);
            end
          end
          if (enter_end) begin
            DONE_REG <= 1'b1;
          end
        end
        END_ST: begin
          DONE_REG <= 1'b1;
        end
        default: begin
          cnt_nm_q   <= '0;
          cnt_addr_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_writer.sv
module tb_data_writer;

  localparam int NM    = 8;
  localparam int N     = 8;
  localparam int B     = 8;
  localparam int WCW   = N + $clog2(NM) + 1;
  localparam int DEPTH = 2 ** N;
  localparam int TOTAL = NM * DEPTH;

  logic            aclk;
  logic            aresetn;
  logic            s_axis_tvalid;
  logic            s_axis_tready;
  logic [B-1:0]    s_axis_tdata;
  logic            s_axis_tlast;
  logic [NM-1:0]   mem_we;
  logic [N-1:0]    mem_addr;
  logic [NM*B-1:0] mem_di;
  logic            START_REG;
  logic            DONE_REG;
  logic [WCW-1:0]  WCNT_REG;

  int n_cmp;
  int n_err;
  int k;                       // words accepted so far in the current capture
  logic [B-1:0] mem_model [NM][DEPTH];

  data_writer #(.NM(NM), .N(N), .B(B)) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tlast  (s_axis_tlast),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_di        (mem_di),
    .START_REG     (START_REG),
    .DONE_REG      (DONE_REG),
    .WCNT_REG      (WCNT_REG)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < NM; i++)
      for (int a = 0; a < DEPTH; a++)
        mem_model[i][a] = 'x;
  endtask

  // One clock: drive at negedge, note whether a handshake happens, then after
  // the edge check the registered write against word k's expected placement.
  task automatic cycle(input logic vld, input logic [B-1:0] dat, input logic last);
    logic          hs;
    logic [NM-1:0] exp_we;
    @(negedge aclk);
    s_axis_tvalid = vld;
    s_axis_tdata  = dat;
    s_axis_tlast  = last;
    #1;
    hs = vld && s_axis_tready;
    @(posedge aclk);
    #1;
    for (int i = 0; i < NM; i++)
      if (mem_we[i] === 1'b1) mem_model[i][mem_addr] = mem_di[i*B +: B];
    if (hs) begin
      exp_we = '0;
      exp_we[k % NM] = 1'b1;
      chk("wr_we",   128'(mem_we),   128'(exp_we));
      chk("wr_addr", 128'(mem_addr), 128'(k / NM));
      chk("wr_di",   128'(mem_di),   128'({NM{dat}}));
      chk("wr_wcnt", 128'(WCNT_REG), 128'(k + 1));
      k++;
    end else begin
      chk("idle_we", 128'(mem_we), 128'(0));
    end
  endtask

  initial begin
    int c;
    int n;
    int bad;
    n_cmp = 0;
    n_err = 0;
    k = 0;
    aresetn = 1'b0;
    START_REG = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata = '0;
    s_axis_tlast = 1'b0;
    clear_model();

    // Reset state
    repeat (2) @(posedge aclk);
    #1;
    chk("rst_tready", 128'(s_axis_tready), 128'(0));
    chk("rst_we",     128'(mem_we),   128'(0));
    chk("rst_addr",   128'(mem_addr), 128'(0));
    chk("rst_di",     128'(mem_di),   128'(0));
    chk("rst_done",   128'(DONE_REG), 128'(0));
    chk("rst_wcnt",   128'(WCNT_REG), 128'(0));
    @(negedge aclk);
    aresetn = 1'b1;
    repeat (2) cycle(1'b1, 8'hA5, 1'b0);

    // Full fill with tvalid held high
    START_REG = 1'b1;
    for (c = 0; c < 3000 && k < TOTAL; c++) cycle(1'b1, B'($urandom), 1'b0);
    chk("fill_count", 128'(k), 128'(TOTAL));
    chk("fill_last_we",   128'(mem_we),   128'(8'h80));
    chk("fill_last_addr", 128'(mem_addr), 128'(8'hFF));
    chk("fill_wcnt",   128'(WCNT_REG), 128'(TOTAL));
    chk("fill_done",   128'(DONE_REG), 128'(1));
    chk("fill_tready", 128'(s_axis_tready), 128'(0));
    repeat (4) cycle(1'b1, B'($urandom), 1'b0);
    chk("end_stall", 128'(s_axis_tready), 128'(0));
    START_REG = 1'b0;
    repeat (4) cycle(1'b0, '0, 1'b0);
    chk("done_hold",   128'(DONE_REG), 128'(1));
    chk("init_tready", 128'(s_axis_tready), 128'(0));

    // Second capture ending on tlast at word 10
    k = 0;
    START_REG = 1'b1;
    for (c = 0; c < 10 && s_axis_tready !== 1'b1; c++) cycle(1'b0, '0, 1'b0);
    chk("rearm_ready", 128'(s_axis_tready), 128'(1));
    chk("rearm_wcnt",  128'(WCNT_REG), 128'(0));
    chk("rearm_done",  128'(DONE_REG), 128'(0));
    for (c = 0; c < 40 && k < 11; c++) cycle(1'b1, B'($urandom), (k == 10));
    chk("tlast_count",  128'(k), 128'(11));
    chk("tlast_we",     128'(mem_we),   128'(8'h04));
    chk("tlast_addr",   128'(mem_addr), 128'(1));
    chk("tlast_wcnt",   128'(WCNT_REG), 128'(11));
    chk("tlast_done",   128'(DONE_REG), 128'(1));
    repeat (5) cycle(1'b1, B'($urandom), 1'b0);
    chk("tlast_stall", 128'(s_axis_tready), 128'(0));
    START_REG = 1'b0;
    repeat (4) cycle(1'b0, '0, 1'b0);
    chk("tlast_init_tready", 128'(s_axis_tready), 128'(0));

    // Bursty tvalid, data = word index
    k = 0;
    clear_model();
    START_REG = 1'b1;
    for (c = 0; c < 9000 && k < TOTAL; c++) begin
      if ($urandom_range(0, 1) == 1) cycle(1'b1, B'(k), 1'b0);
      else cycle(1'b0, B'($urandom), 1'b0);
    end
    chk("burst_count", 128'(k), 128'(TOTAL));
    for (int i = 0; i < NM; i++) begin
      bad = 0;
      for (int a = 0; a < DEPTH; a++)
        if (mem_model[i][a] !== B'(a * NM + i)) bad++;
      chk($sformatf("burst_lane%0d_bad", i), 128'(bad), 128'(0));
    end
    START_REG = 1'b0;
    repeat (4) cycle(1'b0, '0, 1'b0);

    // START dropped while the 100th word is offered
    k = 0;
    START_REG = 1'b1;
    for (c = 0; c < 200 && k < 99; c++) cycle(1'b1, B'($urandom), 1'b0);
    chk("drop_pre_count", 128'(k), 128'(99));
    START_REG = 1'b0;
    n = 0;
    while (s_axis_tready === 1'b1 && n < 10) begin
      cycle(1'b1, B'($urandom), 1'b0);
      n++;
    end
    chk("drop_latency_le3", 128'(n <= 3), 128'(1));
    chk("drop_wcnt_range", 128'(WCNT_REG >= 100 && WCNT_REG <= 102), 128'(1));
    chk("drop_wcnt_model", 128'(WCNT_REG), 128'(k));
    chk("drop_done", 128'(DONE_REG), 128'(1));
    repeat (4) cycle(1'b0, '0, 1'b0);

    // Asynchronous reset in the middle of a capture
    k = 0;
    START_REG = 1'b1;
    for (c = 0; c < 100 && k < 37; c++) cycle(1'b1, B'($urandom), 1'b0);
    chk("mid_count", 128'(k), 128'(37));
    @(negedge aclk);
    s_axis_tvalid = 1'b0;
    #2;
    aresetn = 1'b0;
    #1;
    chk("arst_tready", 128'(s_axis_tready), 128'(0));
    chk("arst_we",     128'(mem_we),   128'(0));
    chk("arst_addr",   128'(mem_addr), 128'(0));
    chk("arst_di",     128'(mem_di),   128'(0));
    chk("arst_done",   128'(DONE_REG), 128'(0));
    chk("arst_wcnt",   128'(WCNT_REG), 128'(0));
    @(negedge aclk);
    aresetn = 1'b1;
    k = 0;
    for (c = 0; c < 20 && k < 5; c++) cycle(1'b1, B'($urandom), 1'b0);
    chk("post_arst_count", 128'(k), 128'(5));
    chk("post_arst_wcnt",  128'(WCNT_REG), 128'(5));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
